// File: rtl/logic_op_if.sv
// Stream bundle for logic_op_pipe: producer-side transaction inputs,
// consumer-side result outputs and the sticky accumulator view.
interface logic_op_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [2:0]                in_op;
    logic                      in_acc;
    logic                      acc_clear;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic                      out_any;
    logic [WIDTH-1:0]          acc_value;

    // Environment side: drives transactions and consumes results.
    modport master (
        output in_valid, in_data, in_op, in_acc, acc_clear, out_ready,
        input  in_ready, out_valid, out_data, out_any, acc_value
    );

    // Block side: accepts transactions and produces results.
    modport slave (
        input  in_valid, in_data, in_op, in_acc, acc_clear, out_ready,
        output in_ready, out_valid, out_data, out_any, acc_value
    );
endinterface

// File: rtl/logic_op_pipe.sv
// Two-stage registered N-input bitwise logic unit with valid/ready on both
// sides and an optional sticky-OR accumulator applied at the output stage.
module logic_op_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4
) (
    input  logic        clk,
    input  logic        rst,
    logic_op_if.slave   bus
);

    localparam logic [2:0] OP_OR   = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;

    // Reduce all operands with the selected op; inverting ops invert the
    // full reduction, and the reserved code yields zero.
    function automatic logic [WIDTH-1:0] op_reduce(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [2:0]              op
    );
        logic [WIDTH-1:0] or_v;
        logic [WIDTH-1:0] and_v;
        logic [WIDTH-1:0] xor_v;
        logic [WIDTH-1:0] res;
        or_v  = '0;
        and_v = '1;
        xor_v = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            or_v  = or_v  | data[k*WIDTH +: WIDTH];
            and_v = and_v & data[k*WIDTH +: WIDTH];
            xor_v = xor_v ^ data[k*WIDTH +: WIDTH];
        end
        case (op)
            OP_OR:   res = or_v;
            OP_AND:  res = and_v;
            OP_XOR:  res = xor_v;
            OP_NOR:  res = ~or_v;
            OP_NAND: res = ~and_v;
            OP_XNOR: res = ~xor_v;
            OP_PASS: res = data[WIDTH-1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_result_r;
    logic               s1_acc_r;
    logic               s2_valid_r;
    logic [WIDTH-1:0]   out_data_r;
    logic               out_any_r;
    logic [WIDTH-1:0]   acc_value_r;

    logic               s2_load_s;
    logic               s1_advance_s;
    logic [WIDTH-1:0]   acc_eff_s;
    logic [WIDTH-1:0]   s2_next_s;
    logic [WIDTH-1:0]   op_result_s;

    // Flow control and next-value datapath; in_ready never depends on in_valid.
    always_comb begin
        s2_load_s    = s1_valid_r && (!s2_valid_r || bus.out_ready);
        s1_advance_s = !s1_valid_r || s2_load_s;
        acc_eff_s    = bus.acc_clear ? '0 : acc_value_r;
        s2_next_s    = s1_acc_r ? (s1_result_r | acc_eff_s) : s1_result_r;
        op_result_s  = op_reduce(bus.in_data, bus.in_op);
    end

    // Stage 1: capture the reduced result and accumulate flag on a transfer,
    // or fall empty when advancing without input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_result_r <= '0;
            s1_acc_r    <= 1'b0;
        end else if (s1_advance_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_result_r <= op_result_s;
                s1_acc_r    <= bus.in_acc;
            end
        end
    end

    // Stage 2: output register, held while the consumer stalls; an empty S1
    // never overwrites a held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            out_data_r <= '0;
            out_any_r  <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            out_data_r <= s2_next_s;
            out_any_r  <= |s2_next_s;
        end else if (bus.out_ready) begin
            s2_valid_r <= 1'b0;
        end
    end

    // Sticky accumulator: an accumulating load wins (already folding in the
    // same-cycle clear through acc_eff_s); a lone clear zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_value_r <= '0;
        end else if (s2_load_s && s1_acc_r) begin
            acc_value_r <= s2_next_s;
        end else if (bus.acc_clear) begin
            acc_value_r <= '0;
        end
    end

    assign bus.in_ready  = s1_advance_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_any   = out_any_r;
    assign bus.acc_value = acc_value_r;

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe (WIDTH=8, NUM_IN=4) with a per-bit
// counting reference model and an in-order expectation queue.
module tb_logic_op_pipe;
    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   tests_failed = 0;

    // Values observed just before the most recent clock edge.
    bit         in_fire;
    bit         out_fire;
    bit         pre_valid;
    bit         pre_ready;
    logic [W-1:0] pre_data;
    logic       pre_any;

    logic_op_if #(.WIDTH(W), .NUM_IN(N)) bus();

    logic_op_pipe #(.WIDTH(W), .NUM_IN(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: per bit, count how many operands have it set and apply the rule.
    function automatic logic [W-1:0] ref_result(input logic [N*W-1:0] d, input logic [2:0] op);
        logic [W-1:0] r;
        int ones;
        for (int b = 0; b < W; b++) begin
            ones = 0;
            for (int k = 0; k < N; k++) if (d[k*W+b]) ones++;
            case (op)
                3'd0: r[b] = (ones > 0);
                3'd1: r[b] = (ones == N);
                3'd2: r[b] = (ones % 2 == 1);
                3'd3: r[b] = (ones == 0);
                3'd4: r[b] = (ones != N);
                3'd5: r[b] = (ones % 2 == 0);
                3'd6: r[b] = d[b];
                default: r[b] = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic step();
        #2;
        in_fire   = bus.in_valid && bus.in_ready;
        out_fire  = bus.out_valid && bus.out_ready;
        pre_valid = bus.out_valid;
        pre_ready = bus.out_ready;
        pre_data  = bus.out_data;
        pre_any   = bus.out_any;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_op     = 3'd0;
        bus.in_acc    = 1'b0;
        bus.acc_clear = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_any !== 1'b0 ||
            bus.acc_value !== 8'h00 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b d=%h any=%b acc=%h rdy=%b, want 0 00 0 00 1",
                     bus.out_valid, bus.out_data, bus.out_any, bus.acc_value, bus.in_ready);
        end
    endtask

    task automatic test_or();
        bus.in_data   = {8'h08, 8'h04, 8'h02, 8'h01};
        bus.in_op     = 3'b000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (!in_fire || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL or_first_cycle: got fire=%b out_valid=%b, want 1 0", in_fire, bus.out_valid);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h0F || bus.out_any !== 1'b1) begin
            tests_failed++;
            $display("FAIL or_result: got v=%b d=%h any=%b, want 1 0f 1",
                     bus.out_valid, bus.out_data, bus.out_any);
        end
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL or_drain: got out_valid=%b, want 0", bus.out_valid);
        end
    endtask

    task automatic test_op_sweep();
        logic [W-1:0] table_v [8] = '{8'hFF, 8'h80, 8'h69, 8'h00, 8'h7F, 8'h96, 8'hF0, 8'h00};
        int got = 0;
        int first_cyc = -1;
        bus.in_data   = {8'hFF, 8'hAA, 8'hCC, 8'hF0};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            bus.in_valid = (c < 8);
            bus.in_op    = 3'(c);
            step();
            if (out_fire) begin
                if (first_cyc < 0) first_cyc = c;
                tests_run++;
                if (got >= 8 || c != first_cyc + got || pre_data !== table_v[got] ||
                    pre_any !== (|table_v[got])) begin
                    tests_failed++;
                    $display("FAIL op_sweep[%0d]: got d=%h any=%b cyc=%0d, want d=%h cyc=%0d",
                             got, pre_data, pre_any, c, (got < 8) ? table_v[got] : 8'h00, first_cyc + got);
                end
                got++;
            end
        end
        tests_run++;
        if (got != 8) begin
            tests_failed++;
            $display("FAIL op_sweep_count: got %0d results, want 8", got);
        end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] data_v [4];
        logic [2:0]     op_v [4];
        logic [W-1:0]   exp_v [4];
        int idx = 0;
        int got = 0;
        for (int i = 0; i < 4; i++) begin
            data_v[i] = {$urandom, $urandom};
            op_v[i]   = 3'($urandom_range(0, 6));
            exp_v[i]  = ref_result(data_v[i], op_v[i]);
        end
        bus.out_ready = 1'b0;
        bus.in_acc    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_data  = data_v[idx % 4];
            bus.in_op    = op_v[idx % 4];
            step();
            if (in_fire) idx++;
        end
        #2;
        tests_run++;
        if (idx != 2 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_data !== exp_v[0]) begin
            tests_failed++;
            $display("FAIL bp_stall: got accepted=%0d rdy=%b v=%b d=%h, want 2 0 1 %h",
                     idx, bus.in_ready, bus.out_valid, bus.out_data, exp_v[0]);
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            bus.in_valid = (idx < 4);
            bus.in_data  = data_v[idx % 4];
            bus.in_op    = op_v[idx % 4];
            step();
            if (in_fire) idx++;
            if (out_fire) begin
                tests_run++;
                if (pre_data !== exp_v[got]) begin
                    tests_failed++;
                    $display("FAIL bp_order[%0d]: got %h, want %h", got, pre_data, exp_v[got]);
                end
                got++;
            end
        end
        bus.in_valid = 1'b0;
        step();
        tests_run++;
        if (got != 4 || idx != 4 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_count: got out=%0d in=%0d v=%b, want 4 4 0", got, idx, bus.out_valid);
        end
    endtask

    // Send one pass-op transaction and check the output and accumulator once it loads.
    task automatic acc_send(input logic [W-1:0] d0, input bit acc, input bit clear,
                            inout logic [W-1:0] acc_m);
        logic [W-1:0] exp_out;
        bus.in_data   = {$urandom, 8'(d0)};
        bus.in_data[W-1:0] = d0;
        bus.in_op     = 3'b110;
        bus.in_acc    = acc;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        bus.in_acc    = 1'b0;
        bus.acc_clear = clear;
        step();
        bus.acc_clear = 1'b0;
        if (acc) begin
            exp_out = clear ? d0 : (acc_m | d0);
            acc_m   = exp_out;
        end else begin
            exp_out = d0;
            if (clear) acc_m = '0;
        end
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp_out || bus.acc_value !== acc_m) begin
            tests_failed++;
            $display("FAIL acc_%h: got v=%b d=%h acc=%h, want 1 %h %h",
                     d0, bus.out_valid, bus.out_data, bus.acc_value, exp_out, acc_m);
        end
        step();
    endtask

    task automatic test_accumulate();
        logic [W-1:0] acc_m = '0;
        apply_reset();
        acc_send(8'h01, 1'b1, 1'b0, acc_m);
        acc_send(8'h10, 1'b1, 1'b0, acc_m);
        acc_send(8'h80, 1'b1, 1'b0, acc_m);
        acc_send(8'h04, 1'b1, 1'b1, acc_m);
        acc_send(8'h55, 1'b0, 1'b0, acc_m);
        bus.acc_clear = 1'b1;
        step();
        bus.acc_clear = 1'b0;
        acc_m = '0;
        tests_run++;
        if (bus.acc_value !== 8'h00) begin
            tests_failed++;
            $display("FAIL acc_clear_alone: got %h, want 00", bus.acc_value);
        end
        acc_send(8'h20, 1'b1, 1'b0, acc_m);
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        apply_reset();
        bus.out_ready = 1'b0;
        bus.in_op     = 3'b110;
        bus.in_acc    = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = {24'h0, 8'h3C};
        step();
        bus.in_data   = {24'h0, 8'hC3};
        step();
        bus.in_valid  = 1'b0;
        bus.in_acc    = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.acc_value !== 8'h3C) begin
            tests_failed++;
            $display("FAIL mid_pre: got v=%b acc=%h, want 1 3c", bus.out_valid, bus.acc_value);
        end
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.acc_value !== 8'h00 || bus.out_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL mid_async: got v=%b acc=%h d=%h, want 0 00 00",
                     bus.out_valid, bus.acc_value, bus.out_data);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (bus.out_valid !== 1'b0) stale++;
        end
        tests_run++;
        if (stale != 0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_stale: got stale=%0d rdy=%b, want 0 1", stale, bus.in_ready);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_q [$];
        logic [W-1:0] acc_m = '0;
        logic [W-1:0] r;
        logic [W-1:0] e;
        int n_in = 0;
        int n_out = 0;
        apply_reset();
        for (int c = 0; c < 420; c++) begin
            bit drain = (c >= 400);
            bus.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
            bus.in_data   = {$urandom};
            bus.in_op     = 3'($urandom_range(0, 7));
            bus.in_acc    = 1'($urandom_range(0, 1));
            bus.out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
            step();
            if (in_fire) begin
                r = ref_result(bus.in_data, bus.in_op);
                if (bus.in_acc) begin
                    r     = r | acc_m;
                    acc_m = r;
                end
                exp_q.push_back(r);
                n_in++;
            end
            if (out_fire) begin
                n_out++;
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("FAIL rand_extra: got %h with nothing expected", pre_data);
                end else begin
                    e = exp_q.pop_front();
                    if (pre_data !== e || pre_any !== (|e)) begin
                        tests_failed++;
                        $display("FAIL rand_data: got d=%h any=%b, want d=%h any=%b",
                                 pre_data, pre_any, e, |e);
                    end
                end
            end
            if (pre_valid && !pre_ready) begin
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== pre_data || bus.out_any !== pre_any) begin
                    tests_failed++;
                    $display("FAIL rand_stall_hold: got v=%b d=%h, want 1 %h",
                             bus.out_valid, bus.out_data, pre_data);
                end
            end
        end
        tests_run++;
        if (n_in != n_out || exp_q.size() != 0 || bus.acc_value !== acc_m) begin
            tests_failed++;
            $display("FAIL rand_totals: got in=%0d out=%0d left=%0d acc=%h, want equal counts, 0 left, acc=%h",
                     n_in, n_out, exp_q.size(), bus.acc_value, acc_m);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_or();
        test_op_sweep();
        test_backpressure();
        test_accumulate();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
